// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and FSM state encoding
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_DATA_BIT  = 3'd2,
        ST_STOP_BIT  = 3'd3,
        ST_CLEANUP   = 3'd4
    } uart_state_e;

    // Offset from the start-bit falling edge to the middle of the start bit.
    function automatic logic [7:0] half_bit(input int clks_per_bit);
        return 8'((clks_per_bit - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is selectable so idle-high lines do not look like a start bit.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta     <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: qualifies the start bit at mid-bit, samples each data bit at mid-bit,
// checks the stop bit and strobes either a good byte or a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       rx_serial_data,
    output logic       rx_data_valid,
    output logic [7:0] out,
    output logic       rx_active,
    output logic       rx_frame_error
);

    localparam logic [7:0] HALF     = half_bit(CLKS_PER_BIT);
    localparam logic [7:0] LAST     = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state;
    logic        rx_s;
    logic [7:0]  clk_count;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic        armed;

    uart_rx_sync #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .async_in(rx_serial_data),
        .sync_out(rx_s)
    );

    // armed is cleared by a framing error so a line stuck low (break) cannot retrigger
    // until it has been seen high again.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= ST_IDLE;
            clk_count      <= 8'd0;
            bit_index      <= 3'd0;
            shift          <= 8'd0;
            armed          <= 1'b1;
            out            <= 8'd0;
            rx_data_valid  <= 1'b0;
            rx_frame_error <= 1'b0;
            rx_active      <= 1'b0;
        end else begin
            rx_data_valid  <= 1'b0;
            rx_frame_error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    clk_count <= 8'd0;
                    bit_index <= 3'd0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end
                    if (armed && !rx_s) begin
                        state     <= ST_START_BIT;
                        rx_active <= 1'b1;
                    end
                end

                ST_START_BIT: begin
                    if (clk_count == HALF) begin
                        clk_count <= 8'd0;
                        if (!rx_s) begin
                            state <= ST_DATA_BIT;
                        end else begin
                            state     <= ST_IDLE;
                            rx_active <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                ST_DATA_BIT: begin
                    if (clk_count == LAST) begin
                        clk_count        <= 8'd0;
                        shift[bit_index] <= rx_s;
                        if (bit_index == LAST_BIT) begin
                            bit_index <= 3'd0;
                            state     <= ST_STOP_BIT;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                ST_STOP_BIT: begin
                    if (clk_count == LAST) begin
                        clk_count <= 8'd0;
                        rx_active <= 1'b0;
                        state     <= ST_CLEANUP;
                        if (rx_s) begin
                            out           <= shift;
                            rx_data_valid <= 1'b1;
                        end else begin
                            rx_frame_error <= 1'b1;
                            armed          <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                ST_CLEANUP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
